ultrasonic_ranger: RTL

//   Drives one HC-SR04-style ultrasonic sensor: issues a periodic trigger pulse,

---
 rtl/ultrasonic_ranger.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - HC-SR04 style ranger: periodic trigger, echo timing, cm conversion
// Echo is synchronised, timed in microsecond ticks and floor-divided into cm by a wrapping sub-counter.
module ultrasonic_ranger #(
  parameter int          CLK_PER_US = 1,
  parameter int          TRIG_US    = 10,
  parameter int          PERIOD_US  = 60000,
  parameter int          TIMEOUT_US = 30000,
  parameter int          US_PER_CM  = 58,
  parameter int          THRESH_CM  = 13,
  parameter logic [15:0] MAX_CM     = 16'd517
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance_cm,
  output logic        sample_valid,
  output logic        timeout,
  output logic        obstacle
);

  localparam int PW  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int TW  = $clog2(TIMEOUT_US + TRIG_US + 1);
  localparam int SW  = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  // Wide enough for a worst-case cycle that overruns the nominal period.
  localparam int PCW = $clog2(PERIOD_US + TRIG_US + 2 * TIMEOUT_US + 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic           echo_meta_q, echo_sync_q, echo_prev_q;
  logic [PW-1:0]  pre_q, pre_d;
  logic [PCW-1:0] per_q, per_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [SW-1:0]  sub_q, sub_d;
  logic [15:0]    cm_q, cm_d;
  logic           armed_q, armed_d;
  logic           to_q, to_d;
  logic [15:0]    dist_q, dist_d;
  logic           sv_q, sv_d;
  logic           tout_q, tout_d;
  logic           obst_q, obst_d;

  logic tick, rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sync_q;
    end
  end

  assign tick = (pre_q == PW'(CLK_PER_US - 1));
  // A rise only counts after echo has been seen low inside WAIT_RISE.
  assign rise = armed_q && echo_sync_q;
  assign fall = echo_prev_q && !echo_sync_q;

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);
    per_d   = tick ? per_q + PCW'(1) : per_q;
    tmr_d   = tmr_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    armed_d = armed_q;
    to_d    = to_q;
    dist_d  = dist_q;
    sv_d    = 1'b0;
    tout_d  = tout_q;
    obst_d  = obst_q;
    trig    = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_TRIG;
        pre_d   = '0;
        per_d   = '0;
        tmr_d   = '0;
      end
      S_TRIG: begin
        trig = 1'b1;
        if (tick) begin
          if (tmr_q == TW'(TRIG_US - 1)) begin
            state_d = S_WAIT_RISE;
            tmr_d   = '0;
            armed_d = 1'b0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      S_WAIT_RISE: begin
        if (!echo_sync_q) armed_d = 1'b1;
        if (rise) begin
          state_d = S_MEASURE;
          cm_d    = '0;
          sub_d   = '0;
          tmr_d   = '0;
          to_d    = 1'b0;
        end else if (tick) begin
          if (tmr_q == TW'(TIMEOUT_US - 1)) begin
            state_d = S_DONE;
            to_d    = 1'b1;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      S_MEASURE: begin
        if (tick) begin
          tmr_d = tmr_q + TW'(1);
          if (sub_q == SW'(US_PER_CM - 1)) begin
            sub_d = '0;
            if (cm_q != 16'hFFFF) cm_d = cm_q + 16'd1;
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
        // Fall is checked first so a fall on the timeout tick still yields a valid sample.
        if (fall) begin
          state_d = S_DONE;
          to_d    = 1'b0;
        end else if (tick && tmr_q == TW'(TIMEOUT_US - 1)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
      end
      S_DONE: begin
        sv_d    = 1'b1;
        dist_d  = to_q ? MAX_CM : cm_q;
        tout_d  = to_q;
        obst_d  = !to_q && (cm_q <= 16'(THRESH_CM));
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (tick && per_q >= PCW'(PERIOD_US - 1)) begin
          state_d = S_TRIG;
          pre_d   = '0;
          per_d   = '0;
          tmr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      per_q   <= '0;
      tmr_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      armed_q <= 1'b0;
      to_q    <= 1'b0;
      dist_q  <= MAX_CM;
      sv_q    <= 1'b0;
      tout_q  <= 1'b0;
      obst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      per_q   <= per_d;
      tmr_q   <= tmr_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      armed_q <= armed_d;
      to_q    <= to_d;
      dist_q  <= dist_d;
      sv_q    <= sv_d;
      tout_q  <= tout_d;
      obst_q  <= obst_d;
    end
  end

  assign distance_cm  = dist_q;
  assign sample_valid = sv_q;
  assign timeout      = tout_q;
  assign obstacle     = obst_q;

endmodule
